// File: rtl/clock_mode_controller_if.sv
// Button inputs and status outputs of the HH:MM:SS clock sequencer, bundled for
// the controller (slave) and whatever drives its buttons and watches its outputs (master).
interface clock_mode_controller_if;
    // No valid/ready handshake: buttons are plain levels, their rising edge is the event;
    // all outputs are registered state, or decodes of it, and are valid every cycle.
    logic        btn_clear;
    logic        btn_mode;
    logic        btn_next;
    logic        btn_inc;
    logic [3:0]  state;
    logic [25:0] rCount;
    logic        canIMove;
    logic        tick;
    logic [23:0] setBits;
    logic [2:0]  digitSel;
    logic [5:0]  blankMask;

    modport master (
        output btn_clear, btn_mode, btn_next, btn_inc,
        input  state, rCount, canIMove, tick, setBits, digitSel, blankMask
    );

    modport slave (
        input  btn_clear, btn_mode, btn_next, btn_inc,
        output state, rCount, canIMove, tick, setBits, digitSel, blankMask
    );
endinterface

// File: rtl/clock_mode_controller.sv
// Mode FSM (RESET/SET/RUN), one-second prescaler and set-mode digit editor for the six-digit clock.
// Optional digit blinking in SET is built when CLKCTRL_BLINK_EN is defined.
module clock_mode_controller #(
    parameter int unsigned TICK_MAX = 49999999
) (
    input logic                    clk,
    input logic                    rst_n,
    clock_mode_controller_if.slave bus
);
    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_SET   = 4'd1,
        ST_RUN   = 4'd3
    } mode_t;

    localparam logic [25:0] TICK_LAST = 26'(TICK_MAX);

    logic [3:0]  btnRaw, syncA, syncB, btnPrev, btnPulse;
    logic        clrPulse, modePulse, nextPulse, incPulse;
    mode_t       stateQ, stateNext;
    logic [23:0] setQ, setNext;
    logic [2:0]  selQ, selNext;
    logic [4:0]  digitBase;
    logic [3:0]  curDigit, digitLimit, bumped;
    logic [25:0] rCountQ, rCountNext;

    // Bit order: 0 clear, 1 mode, 2 next, 3 inc.
    assign btnRaw = {bus.btn_inc, bus.btn_next, bus.btn_mode, bus.btn_clear};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncA   <= '0;
            syncB   <= '0;
            btnPrev <= '0;
        end else begin
            syncA   <= btnRaw;
            syncB   <= syncA;
            btnPrev <= syncB;
        end
    end

    assign btnPulse  = syncB & ~btnPrev;
    // Only the highest-priority pulse acts: clear > mode > next > inc.
    assign clrPulse  = btnPulse[0];
    assign modePulse = btnPulse[1] & ~btnPulse[0];
    assign nextPulse = btnPulse[2] & ~|btnPulse[1:0];
    assign incPulse  = btnPulse[3] & ~|btnPulse[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateQ <= ST_RESET;
        else        stateQ <= stateNext;
    end

    always_comb begin
        stateNext = stateQ;
        if (clrPulse) begin
            stateNext = ST_RESET;
        end else if (modePulse) begin
            case (stateQ)
                ST_RESET: stateNext = ST_SET;
                ST_SET:   stateNext = ST_RUN;
                default:  stateNext = ST_RESET;
            endcase
        end
    end

    always_comb begin
        setNext   = setQ;
        selNext   = selQ;
        digitBase = {selQ, 2'b00};
        curDigit  = setQ[digitBase +: 4];
        case (selQ)
            3'd0, 3'd2: digitLimit = 4'd9;
            3'd1, 3'd3: digitLimit = 4'd5;
            3'd4:       digitLimit = (setQ[23:20] == 4'd2) ? 4'd3 : 4'd9;
            default:    digitLimit = 4'd2;
        endcase
        bumped = (curDigit >= digitLimit) ? 4'd0 : curDigit + 4'd1;

        if (clrPulse) begin
            setNext = '0;
        end else if (stateQ != ST_SET) begin
            if (stateNext == ST_SET) selNext = 3'd0;
        end else if (nextPulse) begin
            selNext = (selQ >= 3'd5) ? 3'd0 : selQ + 3'd1;
        end else if (incPulse) begin
            setNext[digitBase +: 4] = bumped;
            // Reaching 20-something hours clamps an out-of-range hour units digit.
            if (selQ == 3'd5 && bumped == 4'd2 && setQ[19:16] > 4'd3) setNext[19:16] = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setQ <= '0;
            selQ <= '0;
        end else begin
            setQ <= setNext;
            selQ <= selNext;
        end
    end

    always_comb begin
        rCountNext = '0;
        if (stateQ == ST_RUN && stateNext == ST_RUN) begin
            rCountNext = (rCountQ == TICK_LAST) ? 26'd0 : rCountQ + 26'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rCountQ <= '0;
        else        rCountQ <= rCountNext;
    end

`ifdef CLKCTRL_BLINK_EN
    localparam logic [25:0] BLINK_HALF = 26'(TICK_MAX / 2);
    logic [25:0] blinkQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blinkQ <= '0;
        end else if (stateQ == ST_SET && stateNext == ST_SET) begin
            blinkQ <= (blinkQ == TICK_LAST) ? 26'd0 : blinkQ + 26'd1;
        end else begin
            blinkQ <= '0;
        end
    end

    assign bus.blankMask = (stateQ == ST_SET && blinkQ > BLINK_HALF) ? (6'd1 << selQ) : 6'd0;
`else
    assign bus.blankMask = 6'd0;
`endif

    assign bus.state    = stateQ;
    assign bus.rCount   = rCountQ;
    assign bus.canIMove = (stateQ == ST_RUN);
    assign bus.tick     = (stateQ == ST_RUN) && (rCountQ == TICK_LAST);
    assign bus.setBits  = setQ;
    assign bus.digitSel = selQ;
endmodule

// File: doc/clock_mode_controller.md
# clock_mode_controller

Sequencer for the six-digit HH:MM:SS clock. It owns the mode state machine (reset, set, run), the one-second prescaler and the run-enable. It also holds the set-mode digit editor that produces the preload value for every digit slice. Its `state`, `rCount`, `canIMove` and `setBits` outputs drive all six digit modules directly.

## Interface
- `TICK_MAX`, default 49999999: terminal prescaler count; one second at 50 MHz. Must fit in 26 bits.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_clear`  in  1  raw push-button, asynchronous to `clk`; forces RESET mode and clears `setBits`.
- `btn_mode`  in  1  raw push-button; advances the mode.
- `btn_next`  in  1  raw push-button; in SET, selects the next digit.
- `btn_inc`  in  1  raw push-button; in SET, increments the selected digit.
- `state`  out  4  mode code to digit modules: 0 = RESET, 1 = SET, 3 = RUN.
- `rCount`  out  26  prescaler value.
- `canIMove`  out  1  high only in RUN.
- `tick`  out  1  high while in RUN and `rCount == TICK_MAX`.
- `setBits`  out  24  packed preload digits: [3:0] LSB (seconds units), [7:4] HSB, [11:8] LMB, [15:12] HMB, [19:16] LHB, [23:20] HHB.
- `digitSel`  out  3  digit under edit, 0 (LSB) to 5 (HHB).
- `blankMask`  out  6  one bit per digit; 1 = blank that digit on the display.

## Operation
- **Button front end**
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector that produces a 1-cycle internal pulse.
  - No debounce is done here; inputs are already debounced.
- **Priority on simultaneous pulses:** clear > mode > next > inc. Only the highest-priority pulse acts; the others are dropped.
- **Mode FSM**
  - RESET: `mode` → SET.
  - SET: `mode` → RUN.
  - RUN: `mode` → RESET. There is no RUN → SET path.
  - `clear` in any mode → RESET and `setBits` = 0.
- **Entering SET:** `digitSel` loads 0.
- **In SET, `next`:** `digitSel` += 1; 5 wraps to 0.
- **In SET, `inc`:** the selected digit steps by one and wraps to 0 past its limit.
  - Limits: LSB 9, HSB 5, LMB 9, HMB 5, HHB 2.
  - LHB limit is 9, or 3 when HHB == 2.
  - If HHB steps to 2 while LHB > 3, LHB loads 0 in the same cycle.
- **`next`/`inc` outside SET:** ignored.
- **`setBits` retention:** `setBits` keeps its value across mode changes. Only `rst_n` or `clear` zero it.
- **Prescaler**
  - In RUN, `rCount` counts 0 … `TICK_MAX`, then wraps to 0.
  - In RESET and SET, `rCount` is held at 0.
  - Leaving RUN zeroes `rCount` on the next edge.
- **`canIMove`:** decoded from the registered state; equals (state == RUN).

## Timing
- **Reset values** (`rst_n` low): `state` 0, `rCount` 0, `canIMove` 0, `tick` 0, `setBits` 0, `digitSel` 0, `blankMask` 0.
  - All synchronizer and edge flops clear.
  - Reset takes effect immediately, including mid-RUN or mid-edit.
- **Button latency:** a button rising edge at cycle N produces its internal pulse at N+2. The register update is visible at N+3.
- **Holding a button:** produces exactly one action until the button is released.
- **`tick`:** combinational decode of registered `rCount`. It is high for exactly one cycle per `TICK_MAX+1` cycles.
  - The first `tick` after entering RUN occurs `TICK_MAX` cycles after the first RUN cycle.
- **`canIMove` and `state`:** both change in the same cycle.

## Configuration
- **`CLKCTRL_BLINK_EN` defined:**
  - A 26-bit blink counter runs only in SET and wraps at `TICK_MAX`.
  - While blink counter > `TICK_MAX/2`, `blankMask` = one-hot of `digitSel`; otherwise 0.
  - Outside SET, the blink counter is held at 0 and `blankMask` is 0.
- **`CLKCTRL_BLINK_EN` undefined:** no blink counter is built and `blankMask` is tied to 0. Port list is unchanged.

## Test plan
All scenarios use `TICK_MAX` = 9.
- **Reset:** `rst_n` low mid-RUN with `rCount` = 5 → all outputs reach reset values at once; `state` = 0.
- **Mode cycle:** pulse `mode` three times → `state` goes 1, 3, 0. In RUN, `tick` is high once every 10 cycles and `canIMove` = 1.
- **Set editing:** in SET, `inc` ×3 → `setBits[3:0]` = 3. Then `next` ×5 and `inc` ×3 → HHB wraps 0→1→2→0.
  - Set HHB = 2 with LHB = 7 → LHB becomes 0.
  - With HHB = 2, LHB `inc` from 3 → 0.
- **Simultaneous pulses:** `clear` and `mode` rise together in SET → `state` = 0 and `setBits` = 0. `next` and `inc` together → only `digitSel` changes.
- **Held button:** `btn_inc` held 50 cycles in SET → the selected digit increments exactly once, visible 3 cycles after the rising edge.
- **Blink (`CLKCTRL_BLINK_EN`):** SET with `digitSel` = 2 → `blankMask` = 6'b000100 for cycles 5–9 of every 10, else 0. Entering RUN → `blankMask` = 0.
